// File: rtl/l3_cache_pkg.sv
// Shared definitions for the L3 victim-writeback read path.
//   WORD_WIDTH      width of one writeback beat
//   WORDS_PER_LINE  beats per cache line (also the dirty-mask width)
//   evict_state_e   eviction reader FSM states
package l3_cache_pkg;

  localparam int unsigned WORD_WIDTH     = 64;
  localparam int unsigned WORDS_PER_LINE = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    SEND,
    DONE
  } evict_state_e;

endpackage

// File: rtl/l3_evict_beat_sel.sv
// Combinational beat picker for the dirty-word mask.
//   mask     in   remaining dirty words
//   idx      out  index of the lowest set bit (0 when mask is empty)
//   is_last  out  exactly one bit set
//   any      out  at least one bit set
module l3_evict_beat_sel
  import l3_cache_pkg::*;
(
  input  logic [WORDS_PER_LINE-1:0] mask,
  output logic [2:0]                idx,
  output logic                      is_last,
  output logic                      any
);

  // Scan from the top down so the lowest set bit is the final writer.
  always_comb begin
    idx = '0;
    for (int unsigned i = WORDS_PER_LINE; i > 0; i--) begin
      if (mask[i-1]) idx = 3'(i - 1);
    end
  end

  assign any     = |mask;
  assign is_last = any && ((mask & (mask - 8'd1)) == '0);

endmodule

// File: rtl/l3_evict_reader.sv
// L3 victim writeback read initiator. Accepts one eviction request, reads the
// victim way from the data array (fixed 1-cycle latency), captures the line and
// streams its dirty 64b words, lowest first, on a valid/ready channel.
//   clk, rst            clock, synchronous active-high reset
//   evict_*             eviction request (valid/ready), index, way, dirty mask, address
//   rd_req, rd_index    one-hot data-array read request and set index
//   rd_data             per-way array read data
//   wb_*                writeback beat channel (valid/ready, addr, beat, data, last)
//   evict_done, busy    completion pulse and FSM-not-idle status
// Optional: define L3_EVICT_PARITY_EN to add wb_par (even parity per byte of wb_data).
module l3_evict_reader
  import l3_cache_pkg::*;
#(
  parameter int WAYS        = 16,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 40,
  localparam int WAY_W      = $clog2(WAYS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             evict_valid,
  output logic                             evict_ready,
  input  logic [INDEX_WIDTH-1:0]           evict_index,
  input  logic [WAY_W-1:0]                 evict_way,
  input  logic [WORDS_PER_LINE-1:0]        evict_dirty_mask,
  input  logic [ADDR_WIDTH-1:0]            evict_addr,
  output logic [WAYS-1:0]                  rd_req,
  output logic [INDEX_WIDTH-1:0]           rd_index,
  input  logic [WAYS-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [ADDR_WIDTH-1:0]            wb_addr,
  output logic [2:0]                       wb_beat,
  output logic [WORD_WIDTH-1:0]            wb_data,
  output logic                             wb_last,
  output logic                             evict_done,
  output logic                             busy
`ifdef L3_EVICT_PARITY_EN
  ,
  output logic [7:0]                       wb_par
`endif
);

  evict_state_e state, next_state;

  logic [INDEX_WIDTH-1:0]    idx_q;
  logic [WAY_W-1:0]          way_q;
  logic [WORDS_PER_LINE-1:0] mask_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     line_buf;

  logic [2:0] beat;
  logic       beat_last;
  logic       beat_any;
  logic       accept;
  logic       handshake;

  l3_evict_beat_sel u_beat_sel (
    .mask    (mask_q),
    .idx     (beat),
    .is_last (beat_last),
    .any     (beat_any)
  );

  assign accept    = (state == IDLE) && evict_valid;
  assign handshake = wb_valid && wb_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (evict_dirty_mask == '0) ? DONE : RD;
      RD:   next_state = CAP;
      CAP:  next_state = SEND;
      SEND: if (handshake && beat_last) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The remaining-dirty mask doubles as the beat cursor: each accepted beat
  // clears its bit, so the next lowest set bit is presented without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      way_q    <= '0;
      mask_q   <= '0;
      addr_q   <= '0;
      line_buf <= '0;
    end else begin
      if (accept) begin
        idx_q  <= evict_index;
        way_q  <= evict_way;
        mask_q <= evict_dirty_mask;
        addr_q <= evict_addr & ~ADDR_WIDTH'(63);
      end
      if (state == CAP) line_buf <= rd_data[way_q];
      if (handshake) mask_q <= mask_q & ~(8'd1 << beat);
    end
  end

  always_comb begin
    evict_ready = (state == IDLE);
    busy        = (state != IDLE);
    evict_done  = (state == DONE);
    rd_req      = (state == RD) ? (WAYS'(1) << way_q) : '0;
    rd_index    = idx_q;
    wb_addr     = addr_q;
    wb_valid    = (state == SEND) && beat_any;
    wb_beat     = wb_valid ? beat : '0;
    wb_data     = wb_valid ? line_buf[{beat, 6'b0} +: WORD_WIDTH] : '0;
    wb_last     = wb_valid && beat_last;
  end

`ifdef L3_EVICT_PARITY_EN
  // Derived purely from registered state, so it holds exactly as wb_data does.
  always_comb begin
    wb_par = '0;
    for (int unsigned i = 0; i < 8; i++) wb_par[i] = ^wb_data[i*8 +: 8];
  end
`endif

endmodule

// File: tb/tb_l3_evict_reader.sv
module tb_l3_evict_reader;

  localparam int WAYS = 16;
  localparam int IW   = 12;
  localparam int DW   = 512;
  localparam int AW   = 40;

  logic                     clk;
  logic                     rst;
  logic                     evict_valid;
  logic                     evict_ready;
  logic [IW-1:0]            evict_index;
  logic [3:0]               evict_way;
  logic [7:0]               evict_dirty_mask;
  logic [AW-1:0]            evict_addr;
  logic [WAYS-1:0]          rd_req;
  logic [IW-1:0]            rd_index;
  logic [WAYS-1:0][DW-1:0]  rd_data;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [AW-1:0]            wb_addr;
  logic [2:0]               wb_beat;
  logic [63:0]              wb_data;
  logic                     wb_last;
  logic                     evict_done;
  logic                     busy;
`ifdef L3_EVICT_PARITY_EN
  logic [7:0]               wb_par;
`endif

  l3_evict_reader #(
    .WAYS        (WAYS),
    .INDEX_WIDTH (IW),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .evict_valid      (evict_valid),
    .evict_ready      (evict_ready),
    .evict_index      (evict_index),
    .evict_way        (evict_way),
    .evict_dirty_mask (evict_dirty_mask),
    .evict_addr       (evict_addr),
    .rd_req           (rd_req),
    .rd_index         (rd_index),
    .rd_data          (rd_data),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_addr          (wb_addr),
    .wb_beat          (wb_beat),
    .wb_data          (wb_data),
    .wb_last          (wb_last),
    .evict_done       (evict_done),
    .busy             (busy)
`ifdef L3_EVICT_PARITY_EN
    ,
    .wb_par           (wb_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Contents of the victim line in every way for the current transaction.
  logic [DW-1:0] line_mem [WAYS];

  typedef struct {
    logic [3:0]  way;
    logic [11:0] idx;
    logic [7:0]  mask;
    logic [39:0] addr;
    int          mode;      // 0: always ready, 1: random ready, 2: 5-cycle stall on beat 2
    int          exp_beats;
    int          exp_done;  // cycle offset of evict_done after the accept cycle
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] par8(input logic [63:0] w);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^w[i*8 +: 8];
    return p;
  endfunction

  // Data array: true data only in the cycle after a read request, garbage otherwise.
  initial begin : array_model
    logic pend;
    rd_data = '0;
    forever begin
      @(negedge clk);
      pend = (rd_req != '0);
      @(posedge clk);
      #1;
      for (int w = 0; w < WAYS; w++) rd_data[w] = pend ? line_mem[w] : rand_line();
    end
  end

  task automatic fill_lines();
    for (int w = 0; w < WAYS; w++) line_mem[w] = rand_line();
  endtask

  task automatic run_evict(input vec_t v, input bit abort_at2,
                           output int nbeats, output int done_off);
    logic [2:0]  q[$];
    logic [63:0] exp_word;
    int          stall;
    int          off;
    for (int i = 0; i < 8; i++) if (v.mask[i]) q.push_back(3'(i));
    nbeats = 0; done_off = -1; stall = 0;
    // accept cycle
    @(posedge clk); #1;
    evict_valid = 1'b1; evict_way = v.way; evict_index = v.idx;
    evict_dirty_mask = v.mask; evict_addr = v.addr; wb_ready = 1'b0;
    @(negedge clk);
    check("accept_ready", evict_ready, 1);
    // next cycle: a different request stays valid and must be ignored
    @(posedge clk); #1; off = 1;
    evict_way = 4'($urandom); evict_index = 12'($urandom);
    evict_dirty_mask = 8'($urandom); evict_addr = {8'($urandom), $urandom};
    @(negedge clk);
    check("rd_req_t1", rd_req, (v.mask != 0) ? (64'd1 << v.way) : 64'd0);
    if (v.mask != 0) check("rd_index", rd_index, v.idx);
    check("busy_t1", busy, 1);
    check("ready_t1", evict_ready, 0);
    if (v.mask == 0) begin
      check("wb_valid_clean", wb_valid, 0);
      if (evict_done) done_off = 1;
    end else begin
      @(posedge clk); #1; off = 2;
      @(negedge clk);
      check("rd_req_t2", rd_req, 0);
      check("wb_valid_t2", wb_valid, 0);
      while (q.size() > 0 && off < 200) begin
        @(posedge clk); #1; off++;
        evict_valid = 1'b0;
        if (abort_at2 && q[0] == 3'd2) begin
          wb_ready = 1'b0;
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          @(negedge clk);
          check("rst_wb_valid", wb_valid, 0);
          check("rst_done", evict_done, 0);
          check("rst_ready", evict_ready, 1);
          return;
        end
        case (v.mode)
          0: wb_ready = 1'b1;
          1: wb_ready = 1'($urandom_range(0, 1));
          default: begin
            if (q[0] == 3'd2 && stall < 5) begin
              wb_ready = 1'b0;
              stall++;
            end else begin
              wb_ready = 1'b1;
            end
          end
        endcase
        @(negedge clk);
        exp_word = line_mem[v.way][int'(q[0])*64 +: 64];
        check("wb_valid", wb_valid, 1);
        check("wb_beat", wb_beat, q[0]);
        check("wb_data", wb_data, exp_word);
        check("wb_last", wb_last, (q.size() == 1) ? 1 : 0);
        check("wb_addr", wb_addr, {v.addr[39:6], 6'b0});
`ifdef L3_EVICT_PARITY_EN
        check("wb_par", wb_par, par8(exp_word));
`endif
        check("done_early", evict_done, 0);
        if (wb_ready) begin
          void'(q.pop_front());
          nbeats++;
        end
      end
      for (int k = 0; k < 4 && done_off < 0; k++) begin
        @(posedge clk); #1; off++;
        wb_ready = 1'b0;
        @(negedge clk);
        if (evict_done) done_off = off;
      end
      check("wb_valid_done", wb_valid, 0);
    end
    // back to idle: done is a single-cycle pulse
    @(posedge clk); #1;
    evict_valid = 1'b0; wb_ready = 1'b0;
    @(negedge clk);
    check("idle_ready", evict_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_done", evict_done, 0);
  endtask

  initial begin
    vec_t vt[7];
    vec_t v;
    int   nb, d;

    rst = 1'b1; evict_valid = 1'b0; evict_index = '0; evict_way = '0;
    evict_dirty_mask = '0; evict_addr = '0; wb_ready = 1'b0;
    for (int w = 0; w < WAYS; w++) line_mem[w] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_index", rd_index, 0);
    check("rst_wb_valid0", wb_valid, 0);
    check("rst_wb_last", wb_last, 0);
    check("rst_evict_done", evict_done, 0);
    check("rst_evict_ready", evict_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_beat", wb_beat, 0);
`ifdef L3_EVICT_PARITY_EN
    check("rst_wb_par", wb_par, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    vt[0] = '{4'd3,  12'h0A5, 8'hFF, 40'h12_3456_789A, 0, 8, 11};
    vt[1] = '{4'd5,  12'h123, 8'h81, 40'hAB_CDEF_0123, 0, 2, 5};
    vt[2] = '{4'd9,  12'h3FF, 8'h00, 40'h00_0000_1040, 0, 0, 1};
    vt[3] = '{4'd0,  12'h000, 8'h80, 40'hFF_FFFF_FFFF, 0, 1, 4};
    vt[4] = '{4'd15, 12'hFFF, 8'h5A, 40'h80_0000_003F, 0, 4, 7};
    vt[5] = '{4'd7,  12'h055, 8'hFF, 40'h01_0203_0405, 2, 8, 16};
    vt[6] = '{4'd12, 12'h0AA, 8'h0C, 40'h55_AAAA_5555, 2, 2, 10};

    foreach (vt[i]) begin
      fill_lines();
      run_evict(vt[i], 1'b0, nb, d);
      check("tbl_beats", nb, vt[i].exp_beats);
      check("tbl_done_off", d, vt[i].exp_done);
    end

    // reset after beat 1 of a full line, then a fresh request must complete
    fill_lines();
    v = '{4'd6, 12'h321, 8'hFF, 40'h33_4444_5555, 0, 8, 11};
    run_evict(v, 1'b1, nb, d);
    check("abort_beats", nb, 2);
    fill_lines();
    v = '{4'd2, 12'h777, 8'h3C, 40'h0F_0F0F_0F00, 0, 4, 7};
    run_evict(v, 1'b0, nb, d);
    check("post_rst_beats", nb, 4);
    check("post_rst_done", d, 7);

`ifdef L3_EVICT_PARITY_EN
    fill_lines();
    line_mem[4][63:0] = 64'h0000_0000_0000_0301;
    v = '{4'd4, 12'h010, 8'h01, 40'h00_0000_0100, 0, 1, 4};
    @(posedge clk); #1;
    evict_valid = 1'b1; evict_way = v.way; evict_index = v.idx;
    evict_dirty_mask = v.mask; evict_addr = v.addr; wb_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      evict_valid = 1'b0;
    end
    @(negedge clk);
    // byte0 = 01 (one set bit), byte1 = 03 (two set bits)
    check("par_hand", wb_par, 8'h01);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 wb_ready = 1'b0;
    @(negedge clk);
    check("par_hand_idle", evict_ready, 1);
`endif

    for (int n = 0; n < 40; n++) begin
      fill_lines();
      v.way  = 4'($urandom);
      v.idx  = 12'($urandom);
      v.mask = (n % 8 == 0) ? 8'h00 : 8'($urandom);
      v.addr = {8'($urandom), $urandom};
      v.mode = 1;
      v.exp_beats = $countones(v.mask);
      v.exp_done  = 0;
      run_evict(v, 1'b0, nb, d);
      check("rnd_beats", nb, v.exp_beats);
      check("rnd_done_seen", (d > 0) ? 1 : 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
